mem_responder: RTL

- Synthesizable val/rdy memory responder; the responder end of the mem_req_4B_t / mem_resp_4B_t protocol issued by the processor's imem and dmem ports.
- Word-organised RAM with byte-lane writes, a fixed response latency and a bounded response queue.
- Honours backpressure on resp_rdy and never drops or reorders a response.
- Used as imem/dmem in processor benches, and as a latency-configurable memory stand-in at top level.

---
 rtl/mem_responder_pkg.sv | 50 +++++
 rtl/mem_resp_fifo.sv | 54 +++++
 rtl/mem_responder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types, protocol codes and byte-lane helpers for the mem_responder slice.
// The mem_req_4B_t / mem_resp_4B_t layouts mirror the processor's memory message format.
package mem_responder_pkg;

    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
    localparam logic [2:0] MEM_TYPE_INIT  = 3'd2;

    localparam logic [1:0] RESP_TEST_ERR  = 2'b01;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    // Byte lanes [off .. off+n-1] clipped to the word, where len==0 means n=4.
    function automatic logic [3:0] byte_en(input logic [1:0] len, input logic [1:0] off);
        logic [2:0] n;
        logic [3:0] be;
        n  = (len == 2'd0) ? 3'd4 : {1'b0, len};
        be = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= int'(off) && i < int'(off) + int'(n)) begin
                be[i] = 1'b1;
            end
        end
        return be;
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// Circular response queue with val/rdy on both sides; deq_msg reads as zero when empty.
// DEPTH need not be a power of two.
module mem_resp_fifo
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  mem_resp_4B_t enq_msg,
    input  logic         enq_val,
    output logic         enq_rdy,
    output mem_resp_4B_t deq_msg,
    output logic         deq_val,
    input  logic         deq_rdy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    mem_resp_4B_t  entries [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          enq_fire;
    logic          deq_fire;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign enq_rdy  = (count < CW'(DEPTH));
    assign deq_val  = (count != '0);
    assign deq_msg  = deq_val ? entries[head] : '0;
    assign enq_fire = enq_val & enq_rdy;
    assign deq_fire = deq_val & deq_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_fire) tail <= bump(tail);
            if (deq_fire) head <= bump(head);
            count <= count + CW'(enq_fire) - CW'(deq_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) entries[tail] <= enq_msg;
    end

endmodule

// File: rtl/mem_responder.sv
// Val/rdy memory responder: byte-lane RAM, fixed LATENCY delay pipe, OUTQ-bounded response queue.
// Define MEM_RESPONDER_RAND_STALL_EN to inject LFSR-driven stalls on both handshakes.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1,
    parameter int OUTQ    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  mem_req_4B_t  req_msg,
    input  logic         req_val,
    output logic         req_rdy,
    output mem_resp_4B_t resp_msg,
    output logic         resp_val,
    input  logic         resp_rdy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(OUTQ + 1);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] word_idx;
    logic [1:0]    off;
    logic [31:0]   cur;
    logic [31:0]   bm;
    logic [31:0]   wdata;
    logic          do_write;
    mem_resp_4B_t  new_resp;

    logic          req_fire;
    logic          resp_fire;
    logic          req_rdy_q;
    logic          stall;
    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_next;

    mem_resp_4B_t  fifo_enq_msg;
    logic          fifo_enq_val;
    logic          fifo_enq_rdy;
    mem_resp_4B_t  fifo_deq_msg;
    logic          fifo_deq_val;
    logic          unused_ok;

    assign word_idx  = req_msg.addr[AW+1:2];
    assign off       = req_msg.addr[1:0];
    assign cur       = mem[word_idx];
    assign req_fire  = req_val & req_rdy;
    assign resp_fire = resp_val & resp_rdy;
    assign unused_ok = ^{req_msg.addr[31:AW+2], fifo_enq_rdy};

    always_comb begin
        bm                = byte_mask(byte_en(req_msg.len, off));
        wdata             = req_msg.data << {off, 3'b000};
        do_write          = 1'b0;
        new_resp          = '0;
        new_resp.type_    = req_msg.type_;
        new_resp.opaque   = req_msg.opaque;
        new_resp.len      = req_msg.len;
        case (req_msg.type_)
            MEM_TYPE_READ:                 new_resp.data = (cur & bm) >> {off, 3'b000};
            MEM_TYPE_WRITE, MEM_TYPE_INIT: do_write      = 1'b1;
            default:                       new_resp.test = RESP_TEST_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (req_fire && do_write) mem[word_idx] <= (cur & ~bm) | (wdata & bm);
    end

    // LATENCY-1 register stages sit ahead of the queue; LATENCY==1 feeds it straight from the RAM.
    generate
        if (LATENCY == 1) begin : g_nopipe
            assign fifo_enq_val = req_fire;
            assign fifo_enq_msg = new_resp;
        end else begin : g_pipe
            logic [LATENCY-2:0] pipe_val;
            mem_resp_4B_t       pipe_msg [LATENCY-1];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pipe_val <= '0;
                    for (int i = 0; i < LATENCY - 1; i++) pipe_msg[i] <= '0;
                end else begin
                    pipe_val[0] <= req_fire;
                    pipe_msg[0] <= new_resp;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        pipe_val[i] <= pipe_val[i-1];
                        pipe_msg[i] <= pipe_msg[i-1];
                    end
                end
            end

            assign fifo_enq_val = pipe_val[LATENCY-2];
            assign fifo_enq_msg = pipe_msg[LATENCY-2];
        end
    endgenerate

    mem_resp_fifo #(.DEPTH(OUTQ)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .enq_msg (fifo_enq_msg),
        .enq_val (fifo_enq_val),
        .enq_rdy (fifo_enq_rdy),
        .deq_msg (fifo_deq_msg),
        .deq_val (fifo_deq_val),
        .deq_rdy (resp_rdy & ~stall)
    );

    assign resp_val = fifo_deq_val & ~stall;
    assign resp_msg = fifo_deq_msg;

`ifdef MEM_RESPONDER_RAND_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= 16'hACE1;
        else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Ready is registered from the post-edge occupancy, so it never depends on req_val or resp_rdy.
    assign inflight_next = inflight + CW'(req_fire) - CW'(resp_fire);
    assign req_rdy       = req_rdy_q & ~stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight  <= '0;
            req_rdy_q <= 1'b0;
        end else begin
            inflight  <= inflight_next;
            req_rdy_q <= (inflight_next < CW'(OUTQ));
        end
    end

endmodule
